// File: rtl/execute.sv
// Y86-64 execute stage: ALU operand selection and operation, condition-code
// register, branch/move condition evaluation and a sticky halt flag.
module execute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [63:0] valE,
  output logic        Cnd,
  output logic [2:0]  cc,
  output logic        halted
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cc_q, cc_d;
  logic [63:0] alu_a, alu_b, alu_t;
  logic        zf_new, sf_new, of_new;
  logic        set_cc;
  logic        zf, sf, of;
  logic        cond;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case statements can leave one unassigned (latch).
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode)
      I_RRMOVQ, I_OPQ:             alu_a = valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
      I_CALL, I_PUSHQ:             alu_a = -64'sd8;
      I_RET, I_POPQ:               alu_a = 64'd8;
      default:                     alu_a = '0;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
      default:                                                   alu_b = '0;
    endcase
  end

  always_comb begin
    alu_t  = alu_b + alu_a;
    of_new = (alu_a[63] == alu_b[63]) && (alu_t[63] != alu_a[63]);
    if (icode == I_OPQ) begin
      case (ifun)
        4'h0: ;
        4'h1: begin
          alu_t  = alu_b - alu_a;
          of_new = (alu_b[63] != alu_a[63]) && (alu_t[63] != alu_b[63]);
        end
        4'h2: begin
          alu_t  = alu_b & alu_a;
          of_new = 1'b0;
        end
        4'h3: begin
          alu_t  = alu_b ^ alu_a;
          of_new = 1'b0;
        end
        default: begin
          alu_t  = '0;
          of_new = 1'b0;
        end
      endcase
    end
    zf_new = (alu_t == '0);
    sf_new = alu_t[63];
  end

  assign valE   = alu_t;
  assign halted = (state_q == S_HALT);
  assign set_cc = (icode == I_OPQ) && (ifun <= 4'h3) && instr_valid && !imem_error && !halted;

  always_comb begin
    cc_d    = set_cc ? {zf_new, sf_new, of_new} : cc_q;
    state_d = state_q;
    if (state_q == S_RUN && (icode == I_HALT || !instr_valid || imem_error))
      state_d = S_HALT;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q    <= 3'b100;
      state_q <= S_RUN;
    end else begin
      cc_q    <= cc_d;
      state_q <= state_d;
    end
  end

  assign cc = cc_q;
  assign {zf, sf, of} = cc_q;

  always_comb begin
    case (ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = ~zf;
      4'h5:    cond = ~(sf ^ of);
      4'h6:    cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
  end

  // Condition only meaningful for cmovXX / jXX, and suppressed once stopped.
  assign Cnd = (icode == I_RRMOVQ || icode == I_JXX) && !halted && cond;

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage: ALU results, flags,
// condition evaluation, halt behaviour and asynchronous reset.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic        instr_valid, imem_error;
  logic [63:0] valE;
  logic        Cnd;
  logic [2:0]  cc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  execute dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .icode       (icode),
    .ifun        (ifun),
    .valA        (valA),
    .valB        (valB),
    .valC        (valC),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .valE        (valE),
    .Cnd         (Cnd),
    .cc          (cc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs settle before checks.
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; instr_valid = 1'b1; imem_error = 1'b0;
    icode = 4'h7; ifun = 4'h3; valA = '0; valB = '0; valC = '0;

    // 1. Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("reset_cc", cc, 3'b100);
    check("reset_halted", halted, 1'b0);
    check("reset_cnd_je", Cnd, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    step();

    // 2. Subtract and branch
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    check("sub_eq_valE", valE, 64'd0);
    step();
    check("sub_eq_cc", cc, 3'b100);
    drive(4'h6, 4'h1, 64'd6, 64'd5, 64'd0);
    check("sub_neg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("sub_neg_cc", cc, 3'b010);
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    check("jl_after_neg", Cnd, 1'b1);
    drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    check("jge_after_neg", Cnd, 1'b0);
    drive(4'h2, 4'h1, 64'd0, 64'd0, 64'd0);
    check("cmovle_after_neg", Cnd, 1'b1);
    step();

    // 3. Add overflow
    drive(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0);
    check("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
    step();
    check("add_ovf_cc", cc, 3'b011);
    drive(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    check("jge_after_ovf", Cnd, 1'b1);
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    check("jl_after_ovf", Cnd, 1'b0);
    drive(4'h5, 4'h5, 64'd0, 64'd0, 64'd0);
    check("cnd_other_icode", Cnd, 1'b0);

    // 4. Address and stack arithmetic
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    check("pushq_valE", valE, 64'hF8);
    step();
    drive(4'h9, 4'h0, 64'd0, 64'h100, 64'd0);
    check("ret_valE", valE, 64'h108);
    step();
    drive(4'h4, 4'h0, 64'd0, 64'h20, 64'h8);
    check("rmmovq_valE", valE, 64'h28);
    step();
    check("addr_cc_hold", cc, 3'b011);

    // 6. Logic ops and unsupported ifun
    drive(4'h6, 4'h3, 64'h1234, 64'h1234, 64'd0);
    check("xor_valE", valE, 64'd0);
    step();
    check("xor_cc", cc, 3'b100);
    drive(4'h6, 4'h2, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    check("and_valE", valE, 64'h8000_0000_0000_0001);
    step();
    check("and_cc", cc, 3'b010);
    drive(4'h6, 4'h4, 64'd3, 64'd3, 64'd0);
    check("opq_bad_ifun_valE", valE, 64'd0);
    step();
    check("opq_bad_ifun_cc", cc, 3'b010);
    drive(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
    check("jg_after_neg", Cnd, 1'b0);
    drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
    check("j_bad_ifun", Cnd, 1'b0);

    // 5. Halt: icode 0 stops, CC frozen, Cnd forced low, valE still live
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
    check("pre_halt_halted", halted, 1'b0);
    step();
    check("halt_halted", halted, 1'b1);
    drive(4'h6, 4'h1, 64'd7, 64'd7, 64'd0);
    check("halted_valE", valE, 64'd0);
    step();
    check("halted_cc_frozen", cc, 3'b010);
    check("halted_sticky", halted, 1'b1);
    drive(4'h7, 4'h0, 64'd0, 64'd0, 64'd0);
    check("halted_cnd", Cnd, 1'b0);
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
    check("halted_add_valE", valE, 64'd3);

    // Reset clears halted; release while clk is high
    rst_n = 1'b0;
    #1;
    check("rst_clears_halted", halted, 1'b0);
    check("rst_cc_again", cc, 3'b100);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'h6, 4'h1, 64'd6, 64'd5, 64'd0);
    check("rst_release_no_update", cc, 3'b100);
    step();
    check("first_edge_update", cc, 3'b010);

    // OPq with imem_error: no CC write, halts on the same edge
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(4'h6, 4'h1, 64'd6, 64'd5, 64'd0);
    imem_error = 1'b1;
    #1;
    step();
    check("err_cc_hold", cc, 3'b100);
    check("err_halted", halted, 1'b1);
    imem_error = 1'b0;

    // instr_valid low also halts without touching CC
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    drive(4'h6, 4'h1, 64'd6, 64'd5, 64'd0);
    step();
    check("invalid_cc_hold", cc, 3'b100);
    check("invalid_halted", halted, 1'b1);
    instr_valid = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
